// File: rtl/segment_transition_ctrl_if.sv
// segment_transition_ctrl_if: register-file/sequencer bundle for segment_transition_ctrl (master drives requests, slave reports SEGMENT/STOP/BUSY/ERR)
interface segment_transition_ctrl_if #(
  parameter int IDX_WIDTH  = 15,
  parameter int TIME_WIDTH = 64
);
  logic                  UPDATE;
  logic                  REQ_SEGMENT;
  logic [7:0]            TRANSITION_MODE;
  logic [TIME_WIDTH-1:0] TRANSITION_TIME;
  logic [15:0]           REP0;
  logic [15:0]           REP1;
  logic [IDX_WIDTH-1:0]  IDX;
  logic                  IDX_STEP;
  logic [TIME_WIDTH-1:0] SYS_TIME;
  logic                  GPIO_IN;
  logic                  SEGMENT;
  logic                  STOP;
  logic                  BUSY;
  logic                  ERR;
  modport master (
    output UPDATE, REQ_SEGMENT, TRANSITION_MODE, TRANSITION_TIME, REP0, REP1,
           IDX, IDX_STEP, SYS_TIME, GPIO_IN,
    input  SEGMENT, STOP, BUSY, ERR
  );
  modport slave (
    input  UPDATE, REQ_SEGMENT, TRANSITION_MODE, TRANSITION_TIME, REP0, REP1,
           IDX, IDX_STEP, SYS_TIME, GPIO_IN,
    output SEGMENT, STOP, BUSY, ERR
  );
endinterface

// File: rtl/segment_transition_ctrl.sv
// segment_transition_ctrl: schedules the double-buffered segment swap (wrap / system time / GPIO trigger) and counts repeat loops; ports CLK, RST (async high), bus (slave: UPDATE, REQ_SEGMENT, TRANSITION_MODE, TRANSITION_TIME, REP0/1, IDX, IDX_STEP, SYS_TIME, GPIO_IN in; SEGMENT, STOP, BUSY, ERR out); SEGMENT_GPIO_TRIGGER_EN enables GPIO mode
module segment_transition_ctrl #(
  parameter int IDX_WIDTH  = 15,
  parameter int TIME_WIDTH = 64
) (
  input logic                     CLK,
  input logic                     RST,
  segment_transition_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, WAIT_SYNC, WAIT_TIME, WAIT_GPIO} state_t;
  state_t                state, state_n, mode_state;
  logic                  seg, stop, err, pend_seg;
  logic [15:0]           cnt, pend_rep;
  logic [TIME_WIDTH-1:0] pend_time;
  logic                  wrap, trig, mode_ok, gpio_rise, accept;
`ifdef SEGMENT_GPIO_TRIGGER_EN
  // [0],[1] synchronize the pin; [2] holds the previous synchronized level for edge detection
  logic [2:0] gpio_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) gpio_q <= '0;
    else gpio_q <= {gpio_q[1:0], bus.GPIO_IN};
  assign gpio_rise = gpio_q[1] & ~gpio_q[2];
  assign mode_ok   = bus.TRANSITION_MODE <= 8'd2;
`else
  assign gpio_rise = 1'b0;
  assign mode_ok   = bus.TRANSITION_MODE <= 8'd1;
`endif
  assign wrap   = bus.IDX_STEP && bus.IDX == IDX_WIDTH'(0);
  assign accept = bus.UPDATE && mode_ok;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= RUN;
    else state <= state_n;
  always_comb begin
    mode_state = bus.TRANSITION_MODE[1] ? WAIT_GPIO : bus.TRANSITION_MODE[0] ? WAIT_TIME : WAIT_SYNC;
    trig = (state == WAIT_SYNC && wrap) ||
           (state == WAIT_TIME && bus.SYS_TIME >= pend_time) ||
           (state == WAIT_GPIO && gpio_rise);
    // a new request latched on a trigger cycle takes priority for the next state
    state_n = accept ? mode_state : trig ? RUN : state;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      seg       <= 1'b0;
      stop      <= 1'b0;
      err       <= 1'b0;
      cnt       <= 16'hFFFF;
      pend_seg  <= 1'b0;
      pend_rep  <= 16'hFFFF;
      pend_time <= '0;
    end else begin
      if (bus.UPDATE) err <= !mode_ok;
      if (accept) begin
        pend_seg  <= bus.REQ_SEGMENT;
        pend_rep  <= bus.REQ_SEGMENT ? bus.REP1 : bus.REP0;
        pend_time <= bus.TRANSITION_TIME;
      end
      // the switching wrap reloads the counter instead of being counted
      if (trig) begin
        seg  <= pend_seg;
        cnt  <= pend_rep;
        stop <= 1'b0;
      end else if (wrap && !stop && cnt != 16'hFFFF) begin
        if (cnt == 16'd0) stop <= 1'b1;
        else cnt <= cnt - 16'd1;
      end
    end
  assign bus.SEGMENT = seg;
  assign bus.STOP    = stop;
  assign bus.BUSY    = state != RUN;
  assign bus.ERR     = err;
endmodule

// File: tb/tb_segment_transition_ctrl.sv
// tb_segment_transition_ctrl: directed table plus multi-cycle sequences for segment_transition_ctrl
module tb_segment_transition_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  segment_transition_ctrl_if #(.IDX_WIDTH(15), .TIME_WIDTH(64)) bus ();
  segment_transition_ctrl #(.IDX_WIDTH(15), .TIME_WIDTH(64)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        upd;
    logic        rseg;
    logic [7:0]  mode;
    logic [63:0] ttime;
    logic [15:0] rep0;
    logic [15:0] rep1;
    logic        wrap;
    logic [63:0] stime;
    logic [3:0]  exp;
  } vec_t;
  vec_t tbl[$];
  task automatic set(input logic upd, input logic rseg, input logic [7:0] mode, input logic [63:0] tt,
                     input logic [15:0] r0, input logic [15:0] r1, input logic wrap, input logic [63:0] st);
    bus.UPDATE          = upd;
    bus.REQ_SEGMENT     = rseg;
    bus.TRANSITION_MODE = mode;
    bus.TRANSITION_TIME = tt;
    bus.REP0            = r0;
    bus.REP1            = r1;
    bus.IDX             = wrap ? 15'd0 : 15'd3;
    bus.IDX_STEP        = 1'b1;
    bus.SYS_TIME        = st;
  endtask
  task automatic idle(input logic wrap, input logic [63:0] st);
    set(1'b0, 1'b0, 8'd0, 64'd0, 16'hFFFF, 16'hFFFF, wrap, st);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  // exp packs {SEGMENT, STOP, BUSY, ERR}
  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.SEGMENT, bus.STOP, bus.BUSY, bus.ERR};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: seg/stop/busy/err got %b expected %b", name, act, exp);
    end
  endtask
  initial begin
    int sw_at;
    bus.GPIO_IN = 1'b0;
    idle(1'b0, 64'd0);
    //               upd  rseg mode   ttime   rep0      rep1      wrap stime    exp
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b0000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b0000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd0,   4'b0000});
    tbl.push_back('{1'b1, 1'b1, 8'd0, 64'd0,  16'hFFFF, 16'd2,    1'b0, 64'd0,   4'b0010});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd0,   4'b0010});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b1000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b1000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b1000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd0,   4'b1000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b1100});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b1100});
    tbl.push_back('{1'b1, 1'b1, 8'd0, 64'd0,  16'hFFFF, 16'd0,    1'b0, 64'd0,   4'b1110});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b1000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd0,   4'b1100});
    tbl.push_back('{1'b1, 1'b0, 8'd7, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd0,   4'b1101});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 64'd0,  16'd1,    16'hFFFF, 1'b0, 64'd100, 4'b1110});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd100, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd100, 4'b0000});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b1, 64'd100, 4'b0100});
    tbl.push_back('{1'b1, 1'b1, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd100, 4'b0110});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 64'd50, 16'd5,    16'hFFFF, 1'b1, 64'd10,  4'b1010});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd10,  4'b1010});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 64'd0,  16'hFFFF, 16'hFFFF, 1'b0, 64'd60,  4'b0000});
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("reset", 4'b0000);
    foreach (tbl[i]) begin
      set(tbl[i].upd, tbl[i].rseg, tbl[i].mode, tbl[i].ttime, tbl[i].rep0, tbl[i].rep1, tbl[i].wrap, tbl[i].stime);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    // system time counting up to the target
    set(1'b1, 1'b1, 8'd1, 64'd1000, 16'hFFFF, 16'hFFFF, 1'b0, 64'd990);
    tick();
    chk("time_req", 4'b0010);
    sw_at = -1;
    for (int st = 990; st <= 1010; st++) begin
      idle(1'b0, 64'(st));
      tick();
      if (bus.SEGMENT) begin
        sw_at = st;
        break;
      end
    end
    checks++;
    if (sw_at != 1000) begin
      errors++;
      $display("FAIL time_switch: switched after SYS_TIME %0d expected 1000", sw_at);
    end
    chk("time_done", 4'b1000);
    set(1'b1, 1'b0, 8'd1, 64'd500, 16'hFFFF, 16'hFFFF, 1'b0, 64'd1010);
    tick();
    chk("past_t1", 4'b1010);
    idle(1'b0, 64'd1010);
    tick();
    chk("past_t2", 4'b0000);
    // invalid mode keeps the pending time request
    set(1'b1, 1'b1, 8'd1, 64'd20, 16'hFFFF, 16'hFFFF, 1'b0, 64'd0);
    tick();
    chk("inv_req", 4'b0010);
    set(1'b1, 1'b0, 8'd7, 64'd0, 16'hFFFF, 16'hFFFF, 1'b0, 64'd0);
    tick();
    chk("inv_upd", 4'b0011);
    idle(1'b0, 64'd10);
    tick();
    chk("inv_wait", 4'b0011);
    idle(1'b0, 64'd20);
    tick();
    chk("inv_switch", 4'b1001);
    // replacement by a sync request: time no longer matters
    set(1'b1, 1'b0, 8'd1, 64'd40, 16'hFFFF, 16'hFFFF, 1'b0, 64'd25);
    tick();
    chk("repl_time", 4'b1010);
    set(1'b1, 1'b0, 8'd0, 64'd0, 16'hFFFF, 16'hFFFF, 1'b0, 64'd25);
    tick();
    chk("repl_sync", 4'b1010);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0, 64'd50);
      tick();
      chk($sformatf("repl_hold%0d", k), 4'b1010);
    end
    idle(1'b1, 64'd50);
    tick();
    chk("repl_wrap", 4'b0000);
    // asynchronous reset while waiting
    set(1'b1, 1'b1, 8'd0, 64'd0, 16'hFFFF, 16'd0, 1'b0, 64'd0);
    tick();
    chk("rst_req", 4'b0010);
    idle(1'b1, 64'd0);
    tick();
    chk("rst_sw", 4'b1000);
    tick();
    chk("rst_stop", 4'b1100);
    set(1'b1, 1'b0, 8'd0, 64'd0, 16'hFFFF, 16'hFFFF, 1'b0, 64'd0);
    tick();
    chk("rst_pend", 4'b1110);
    set(1'b1, 1'b0, 8'd7, 64'd0, 16'hFFFF, 16'hFFFF, 1'b0, 64'd0);
    tick();
    chk("rst_err", 4'b1111);
    #3 RST = 1'b1;
    #1 chk("rst_async", 4'b0000);
    #2 RST = 1'b0;
    idle(1'b1, 64'd0);
    tick();
    chk("rst_no_sw", 4'b0000);
`ifdef SEGMENT_GPIO_TRIGGER_EN
    idle(1'b0, 64'd0);
    bus.GPIO_IN = 1'b1;
    repeat (4) tick();
    set(1'b1, 1'b1, 8'd2, 64'd0, 16'hFFFF, 16'hFFFF, 1'b0, 64'd0);
    tick();
    chk("gpio_req", 4'b0010);
    idle(1'b0, 64'd0);
    repeat (4) tick();
    chk("gpio_old_edge", 4'b0010);
    bus.GPIO_IN = 1'b0;
    repeat (3) tick();
    bus.GPIO_IN = 1'b1;
    tick();
    chk("gpio_c1", 4'b0010);
    tick();
    chk("gpio_c2", 4'b0010);
    tick();
    chk("gpio_c3", 4'b1000);
`else
    set(1'b1, 1'b1, 8'd2, 64'd0, 16'hFFFF, 16'hFFFF, 1'b0, 64'd0);
    tick();
    chk("gpio_invalid", 4'b0001);
    idle(1'b0, 64'd0);
    tick();
    chk("gpio_invalid_hold", 4'b0001);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/segment_transition_ctrl.md
# segment_transition_ctrl

Schedules the active-segment swap for one double-buffered sequencer (modulation or STM) from the segment, repeat and transition-mode controller registers. It latches a pending segment request, waits for the selected trigger (index wrap, system time or external GPIO edge), then switches `SEGMENT`. After the switch it counts playback loops and raises `STOP` when the finite repeat count is exhausted. One instance sits between the controller register file and each sequencer's index timer.

## Interface
Parameters:
- `IDX_WIDTH`, 15: width of the sequencer sample index.
- `TIME_WIDTH`, 64: width of the system time and transition time.

Ports:
- `CLK`  in  1  system clock; the block has one clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `UPDATE`  in  1  one-cycle pulse; latches a new request from the fields below.
- `REQ_SEGMENT`  in  1  requested segment.
- `TRANSITION_MODE`  in  8  0x00 = SYNC_IDX, 0x01 = SYS_TIME, 0x02 = GPIO; any other code is invalid.
- `TRANSITION_TIME`  in  `TIME_WIDTH`  switch time for SYS_TIME.
- `REP0`, `REP1`  in  16 each  repeat count for each segment; 0xFFFF means infinite.
- `IDX`  in  `IDX_WIDTH`  current sequencer index.
- `IDX_STEP`  in  1  strobe; `IDX` advanced this cycle.
- `SYS_TIME`  in  `TIME_WIDTH`  free-running system time.
- `GPIO_IN`  in  1  asynchronous external trigger.
- `SEGMENT`  out  1  active segment.
- `STOP`  out  1  finite repeat count exhausted; the sequencer holds its last sample.
- `BUSY`  out  1  a transition is pending.
- `ERR`  out  1  last `UPDATE` carried an invalid mode.

## Operation
States:
- `RUN`: the active segment is playing.
- `WAIT_SYNC`: pending transition waiting for the next index wrap.
- `WAIT_TIME`: pending transition waiting for the system time.
- `WAIT_GPIO`: pending transition waiting for a GPIO edge.

Request handling:
- `UPDATE` with a valid mode latches `REQ_SEGMENT`, the mode, `TRANSITION_TIME` and the REP value of the requested segment. It enters the matching `WAIT_*` state and clears `ERR`.
- `UPDATE` with an invalid mode is ignored and sets `ERR`. The state and any pending request are unchanged.
- `UPDATE` while already in a `WAIT_*` state replaces the pending request, including its mode. The previous request is discarded.
- A request for the segment that is already active is still executed: the switch reloads the loop counter and clears `STOP`.

Trigger conditions:
- A wrap is `IDX_STEP` = 1 with `IDX` = 0.
- `WAIT_SYNC` switches on a wrap.
- `WAIT_TIME` switches when `SYS_TIME` ≥ latched time, as an unsigned comparison. A time already in the past switches at the first compare.
- `WAIT_GPIO` switches on a rising edge of `GPIO_IN` after a 2-flip-flop synchronizer. Edges that arrive before entering `WAIT_GPIO` are ignored.

Switch action:
- `SEGMENT` ← pending segment.
- The 16-bit loop counter ← latched REP.
- `STOP` ← 0.
- Return to `RUN`.

Loop counting in `RUN` (also active in the `WAIT_*` states, for the old segment):
- Counter = 0xFFFF: never decrements; `STOP` stays 0.
- Otherwise, on each wrap: if counter = 0, set `STOP`; else decrement.
- N therefore plays N+1 full loops.
- The wrap that causes a SYNC_IDX switch is not counted.
- Wraps are ignored while `STOP` = 1.

## Timing
- Reset values: `SEGMENT` = 0, `STOP` = 0, `BUSY` = 0, `ERR` = 0, state `RUN`, loop counter 0xFFFF, synchronizer flip-flops 0.
- `RST` asserted mid-operation immediately discards any pending request.
- `UPDATE` at cycle t: `BUSY` = 1 and the `WAIT_*` state from t+1. `ERR` updates at t+1.
- SYNC_IDX: wrap sampled at cycle c → `SEGMENT` changes and `BUSY` = 0 at c+1.
- SYS_TIME: compare true at cycle c → switch at c+1. A past time gives a switch at t+2.
- GPIO: pin rising edge sampled at cycle c → switch at c+3 (two synchronizer stages plus the edge register).
- `STOP` rises one cycle after the terminal wrap.
- `UPDATE` coinciding with a trigger cycle: the trigger completes the old request (switch at c+1) and the new request is latched at the same edge, leaving state `WAIT_*` at c+1.

## Configuration
- `SEGMENT_GPIO_TRIGGER_EN` defined: GPIO mode, the synchronizer and `WAIT_GPIO` are compiled in.
- Not defined: mode 0x02 is invalid (sets `ERR`, request ignored), `GPIO_IN` is unused, and no synchronizer flip-flops are built.

## Test plan
- Reset, then wraps with REP0 = 0xFFFF → `SEGMENT` = 0, `STOP` stays 0 indefinitely.
- `UPDATE` (seg 1, SYNC_IDX, REP1 = 2), wrap at cycle c → `SEGMENT` = 1 at c+1; `STOP` = 1 one cycle after the 3rd subsequent wrap, never earlier.
- `UPDATE` (seg 1, SYS_TIME, time 1000) with `SYS_TIME` counting from 990 → switch one cycle after `SYS_TIME` = 1000. Repeat with time 500 → switch at t+2.
- With the macro defined: `UPDATE` (GPIO), `GPIO_IN` rising at cycle c → switch at c+3. Without the macro: same `UPDATE` → `ERR` = 1, `BUSY` = 0, `SEGMENT` unchanged.
- `UPDATE` with mode 0x07 while in `WAIT_TIME` → `ERR` = 1 and the pending time request still switches at its time. A second `UPDATE` (SYNC_IDX) before that time replaces it; only a wrap switches.
- `RST` pulsed while in `WAIT_SYNC` with `SEGMENT` = 1 → all outputs return to reset values immediately; the next wrap causes no switch.
